axi_llc_data_way_pipe: RTL and testbench
========================================

AXI_LLC_DATA_WAY_PIPE -- requirements
Module: axi_llc_data_way_pipe

Interface
REQ-001 Parameter Cfg (axi_llc_pkg::llc_cfg_t), default all-zero: static LLC configuration; SRAM depth SHALL be Cfg.NumLines*Cfg.NumBlocks words of Cfg.BlockSize bits.
REQ-002 Parameter way_inp_t, default logic: request struct with fields cache_unit, way_ind, line_addr, blk_offset, we, data, strb.
REQ-003 Parameter way_oup_t, default logic: response struct with fields cache_unit, data.
REQ-004 Parameter Latency (int unsigned), default 1: SRAM read latency in cycles, legal range 1..8.
REQ-005 Parameter BufDepth (int unsigned), default Latency: response buffer entries, legal range 1..16.
REQ-006 Parameter impl_in_t, default logic: SRAM implementation sideband type.
REQ-007 clk_i  input  1  clock, positive edge triggered.
REQ-008 rst_ni  input  1  asynchronous reset, active low.
REQ-009 test_i  input  1  testmode enable, no functional effect.
REQ-010 ctrl_clr_i  input  1  synchronous clear of all control state.
REQ-011 sram_impl_i  input  impl_in_t  SRAM sideband, passed through unchanged.
REQ-012 inp_i / inp_valid_i / inp_ready_o  input / input / output  way_inp_t / 1 / 1  request channel.
REQ-013 out_o / out_valid_o / out_ready_i  output / output / input  way_oup_t / 1 / 1  read-response channel.
REQ-014 perf_rd_o, perf_wr_o, perf_stall_o  output  32 each  performance counters (see Configuration).

Function
REQ-015 SRAM address SHALL be {inp_i.line_addr, inp_i.blk_offset}; ram_req SHALL be high exactly in cycles where the request handshakes.
REQ-016 Credits = BufDepth - (reads in flight + buffer occupancy); credit consumed on read handshake, returned on output handshake.
REQ-017 inp_ready_o SHALL be 1 when inp_i.we=1 (writes always accepted, no credit), else 1 iff credits>0 or an output handshake occurs this cycle.
REQ-018 A read accepted in cycle t SHALL return SRAM data in cycle t+Latency; that data and its cache_unit (carried in a Latency-deep valid/cache_unit shift pipe) SHALL enter the response buffer.
REQ-019 Response buffer SHALL be FIFO, fall-through: if empty, returning data SHALL appear on out_o with out_valid_o=1 in cycle t+Latency.
REQ-020 Responses SHALL leave in acceptance order; out_o SHALL stay stable while out_valid_o=1 and out_ready_i=0.
REQ-021 Buffer never overflows: credit scheme guarantees occupancy+in-flight <= BufDepth.
REQ-022 With BufDepth >= Latency and out_ready_i=1 continuously, one read per cycle SHALL be sustained.
REQ-023 Simultaneous push and pop on full buffer SHALL be legal; occupancy unchanged.
REQ-024 Writes SHALL never produce a response and never stall behind pending reads.
REQ-025 ctrl_clr_i=1 SHALL in that cycle force inp_ready_o=0, discard in-flight reads and buffer contents, restore credits to BufDepth; out_valid_o=0 from next cycle.
REQ-026 Elaboration SHALL fail with $fatal for Latency or BufDepth outside legal range.

Reset
REQ-027 On rst_ni=0: out_valid_o=0, out_o.cache_unit=axi_llc_pkg::EvictUnit, shift pipe empty, buffer empty, credits=BufDepth, perf counters 0; inp_ready_o=1 from first cycle after reset release.
REQ-028 Reset mid-operation SHALL drop all in-flight and buffered reads without emitting them.

Configuration
REQ-029 Macro AXI_LLC_DATA_WAY_PERF_EN defined: perf_rd_o counts read handshakes, perf_wr_o write handshakes, perf_stall_o cycles with inp_valid_i=1 and inp_ready_o=0; all saturate at 32'hFFFF_FFFF, cleared by ctrl_clr_i.
REQ-030 Macro undefined: perf outputs SHALL be tied to 0, no counter flops.

Verification
REQ-031 Latency=1, BufDepth=1, read addr 5 at t, out_ready_i=1 -> out_valid_o=1 at t+1 with written data.
REQ-032 Latency=3, BufDepth=3, 10 back-to-back reads, out_ready_i=1 -> 10 responses on consecutive cycles t+3..t+12, no stall.
REQ-033 Latency=2, BufDepth=2, out_ready_i=0, 4 reads -> 2 accepted, inp_ready_o=0 for reads, writes still accepted; release out_ready -> 2 responses in order.
REQ-034 Alternating write/read same address -> each read returns data of preceding write, strb-merged bytes correct.
REQ-035 ctrl_clr_i pulse with 2 reads in flight -> no responses emitted, credits full, next read answered normally.
REQ-036 PERF_EN, 5 reads, 3 writes, 4 stall cycles -> perf_rd_o=5, perf_wr_o=3, perf_stall_o=4; without macro all 0.

Source files
------------

// File: rtl/axi_llc_data_way_pipe_if.sv
// Request / read-response channel bundle for the LLC data-way pipeline.
// The slave modport is the pipeline side, the master modport the requester side.
interface axi_llc_data_way_pipe_if #(
  parameter type inp_t = logic,
  parameter type oup_t = logic
) ();
  inp_t inp_i;
  logic inp_valid_i;
  logic inp_ready_o;
  oup_t out_o;
  logic out_valid_o;
  logic out_ready_i;

  modport master (
    output inp_i, inp_valid_i, out_ready_i,
    input  inp_ready_o, out_o, out_valid_o
  );

  modport slave (
    input  inp_i, inp_valid_i, out_ready_i,
    output inp_ready_o, out_o, out_valid_o
  );
endinterface

// File: rtl/axi_llc_data_way_pipe.sv
// LLC data-way pipeline: single-port SRAM with a Latency-deep read pipe and a
// credit-controlled fall-through response FIFO. Writes bypass the credit
// scheme and never generate a response.
// Optional performance counters: define AXI_LLC_DATA_WAY_PERF_EN.
package axi_llc_pkg;
  typedef struct packed {
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned BlockSize;
  } llc_cfg_t;

  typedef enum logic [1:0] {
    WChanUnit = 2'd0,
    RChanUnit = 2'd1,
    EvictUnit = 2'd2,
    RefilUnit = 2'd3
  } cache_unit_e;

  typedef struct packed {
    cache_unit_e cache_unit;
    logic [3:0]  way_ind;
    logic [7:0]  line_addr;
    logic [1:0]  blk_offset;
    logic        we;
    logic [63:0] data;
    logic [7:0]  strb;
  } llc_way_inp_t;

  typedef struct packed {
    cache_unit_e cache_unit;
    logic [63:0] data;
  } llc_way_oup_t;
endpackage

module axi_llc_data_way_pipe #(
  parameter axi_llc_pkg::llc_cfg_t Cfg = axi_llc_pkg::llc_cfg_t'('0),
  parameter type way_inp_t = axi_llc_pkg::llc_way_inp_t,
  parameter type way_oup_t = axi_llc_pkg::llc_way_oup_t,
  parameter int unsigned Latency  = 1,
  parameter int unsigned BufDepth = Latency,
  parameter type impl_in_t = logic
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        test_i,
  input  logic        ctrl_clr_i,
  input  impl_in_t    sram_impl_i,
  axi_llc_data_way_pipe_if.slave bus,
  output logic [31:0] perf_rd_o,
  output logic [31:0] perf_wr_o,
  output logic [31:0] perf_stall_o
);
  way_inp_t w_inp;
  assign w_inp = bus.inp_i;

  localparam int unsigned DataW    = $bits(w_inp.data);
  localparam int unsigned AddrW    = $bits(w_inp.line_addr) + $bits(w_inp.blk_offset);
  localparam int unsigned CfgDepth = Cfg.NumLines * Cfg.NumBlocks;
  localparam int unsigned Depth    = (CfgDepth == 0) ? (1 << AddrW) : CfgDepth;
  localparam int unsigned PtrW     = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned CntW     = $clog2(BufDepth + 1);

  if (Latency < 1 || Latency > 8) begin : g_bad_latency
    $fatal(1, "axi_llc_data_way_pipe: Latency must be 1..8");
  end
  if (BufDepth < 1 || BufDepth > 16) begin : g_bad_bufdepth
    $fatal(1, "axi_llc_data_way_pipe: BufDepth must be 1..16");
  end
  if (Cfg.BlockSize != 0 && Cfg.BlockSize != DataW) begin : g_bad_blocksize
    $fatal(1, "axi_llc_data_way_pipe: Cfg.BlockSize does not match data width");
  end

  logic [DataW-1:0] r_mem [Depth];
  way_oup_t         r_opipe [Latency];
  logic [Latency-1:0] r_vpipe;
  way_oup_t         r_buf [BufDepth];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_cnt, r_credits;

  logic [AddrW-1:0] w_addr;
  logic w_ram_req, w_rd_hs, w_wr_hs, w_inp_ready;
  logic w_ret_v, w_empty, w_out_valid, w_pop, w_push, w_deq;
  way_oup_t w_ret, w_out;
  logic w_unused;

  assign w_unused    = ^{test_i, sram_impl_i, w_inp.way_ind};
  assign w_addr      = {w_inp.line_addr, w_inp.blk_offset};
  assign w_ret_v     = r_vpipe[Latency-1];
  assign w_ret       = r_opipe[Latency-1];
  assign w_empty     = (r_cnt == '0);
  assign w_out_valid = ~w_empty | w_ret_v;
  assign w_pop       = w_out_valid & bus.out_ready_i;
  // An empty buffer lets returning data fall straight through when taken at once.
  assign w_push      = w_ret_v & ~(w_empty & bus.out_ready_i);
  assign w_deq       = w_pop & ~w_empty;
  assign w_inp_ready = ~ctrl_clr_i & (w_inp.we | (r_credits != '0) | w_pop);
  assign w_ram_req   = bus.inp_valid_i & w_inp_ready;
  assign w_rd_hs     = w_ram_req & ~w_inp.we;
  assign w_wr_hs     = w_ram_req & w_inp.we;

  assign bus.inp_ready_o = w_inp_ready;
  assign bus.out_valid_o = w_out_valid;
  assign bus.out_o       = w_out;

  // Response mux: buffer head first, otherwise the data returning this cycle.
  always_comb begin
    w_out = '0;
    w_out.cache_unit = axi_llc_pkg::EvictUnit;
    if (!w_empty)     w_out = r_buf[r_rptr];
    else if (w_ret_v) w_out = w_ret;
  end

  // SRAM array with byte-strobed writes and the read data/cache_unit pipe.
  always_ff @(posedge clk_i) begin
    if (w_wr_hs) begin
      for (int unsigned b = 0; b < DataW / 8; b++) begin
        if (w_inp.strb[b]) r_mem[w_addr][b*8 +: 8] <= w_inp.data[b*8 +: 8];
      end
    end
    if (w_rd_hs) begin
      r_opipe[0].cache_unit <= w_inp.cache_unit;
      r_opipe[0].data       <= r_mem[w_addr];
    end
    for (int unsigned i = 1; i < Latency; i++) r_opipe[i] <= r_opipe[i-1];
  end

  // Valid bits of reads in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vpipe <= '0;
    end else if (ctrl_clr_i) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe[0] <= w_rd_hs;
      for (int unsigned i = 1; i < Latency; i++) r_vpipe[i] <= r_vpipe[i-1];
    end
  end

  // Response buffer storage.
  always_ff @(posedge clk_i) begin
    if (w_push) r_buf[r_wptr] <= w_ret;
  end

  // Buffer pointers, occupancy and credit accounting.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_credits <= CntW'(BufDepth);
    end else if (ctrl_clr_i) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_credits <= CntW'(BufDepth);
    end else begin
      if (w_push) r_wptr <= (r_wptr == PtrW'(BufDepth - 1)) ? '0 : r_wptr + 1'b1;
      if (w_deq)  r_rptr <= (r_rptr == PtrW'(BufDepth - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt     <= r_cnt + CntW'(w_push) - CntW'(w_deq);
      r_credits <= r_credits - CntW'(w_rd_hs) + CntW'(w_pop);
    end
  end

`ifdef AXI_LLC_DATA_WAY_PERF_EN
  logic [31:0] r_perf_rd, r_perf_wr, r_perf_stall;
  logic        w_stall;
  assign w_stall = bus.inp_valid_i & ~w_inp_ready;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_rd    <= '0;
      r_perf_wr    <= '0;
      r_perf_stall <= '0;
    end else if (ctrl_clr_i) begin
      r_perf_rd    <= '0;
      r_perf_wr    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_rd_hs && r_perf_rd    != '1) r_perf_rd    <= r_perf_rd + 32'd1;
      if (w_wr_hs && r_perf_wr    != '1) r_perf_wr    <= r_perf_wr + 32'd1;
      if (w_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_rd_o    = r_perf_rd;
  assign perf_wr_o    = r_perf_wr;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_rd_o    = '0;
  assign perf_wr_o    = '0;
  assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_axi_llc_data_way_pipe.sv
// Bench for axi_llc_data_way_pipe: three instances (Latency/BufDepth 1/1, 3/3,
// 2/2) driven one at a time from shared stimulus, checked against a
// transaction-level model (memory array + ordered response queue with due times).
module tb_axi_llc_data_way_pipe;
  import axi_llc_pkg::*;
  typedef llc_way_inp_t inp_t;
  typedef llc_way_oup_t oup_t;

  localparam llc_cfg_t CFG = '{NumLines: 256, NumBlocks: 4, BlockSize: 64};

  logic clk = 1'b0;
  logic rst_n;
  inp_t req;
  logic req_valid, rdy, clr;
  int   sel;

  logic        ir_a [3];
  logic        ov_a [3];
  oup_t        out_a [3];
  logic [31:0] prd [3];
  logic [31:0] pwr [3];
  logic [31:0] pst [3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { cache_unit_e unit; logic [63:0] data; int due; } rsp_t;
  rsp_t q[$];
  logic [63:0] mem [3][16];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    axi_llc_data_way_pipe_if #(.inp_t(inp_t), .oup_t(oup_t)) u_if ();
    assign u_if.inp_i       = req;
    assign u_if.inp_valid_i = req_valid && (sel == g);
    assign u_if.out_ready_i = rdy && (sel == g);
    assign ir_a[g]  = u_if.inp_ready_o;
    assign ov_a[g]  = u_if.out_valid_o;
    assign out_a[g] = u_if.out_o;
    axi_llc_data_way_pipe #(
      .Cfg(CFG), .way_inp_t(inp_t), .way_oup_t(oup_t),
      .Latency(L), .BufDepth(L), .impl_in_t(logic)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .test_i(1'b0),
      .ctrl_clr_i(clr && (sel == g)), .sram_impl_i(1'b0),
      .bus(u_if.slave),
      .perf_rd_o(prd[g]), .perf_wr_o(pwr[g]), .perf_stall_o(pst[g])
    );
  end

  function automatic int lat_of(int s);
    return (s == 0) ? 1 : (s == 1) ? 3 : 2;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d, dut %0d)", tag, obs, exp, cyc, sel);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model as if the
  // expected handshakes happen at the coming rising edge.
  task automatic cycle();
    bit   ev, ehs, er;
    oup_t e;
    int   i;
    @(negedge clk);
    ev = (q.size() > 0) && (q[0].due <= cyc);
    check("out_valid", ov_a[sel], ev);
    if (ev) begin
      e.cache_unit = q[0].unit;
      e.data       = q[0].data;
      check("out_o", out_a[sel], e);
    end
    ehs = ev && rdy;
    er  = clr ? 1'b0 : (req.we ? 1'b1 : ((q.size() < lat_of(sel)) || ehs));
    check("inp_ready", ir_a[sel], er);
    if (ehs) void'(q.pop_front());
    if (req_valid && er) begin
      i = int'({req.line_addr[1:0], req.blk_offset});
      if (req.we) begin
        for (int b = 0; b < 8; b++)
          if (req.strb[b]) mem[sel][i][b*8 +: 8] = req.data[b*8 +: 8];
      end else begin
        q.push_back('{unit: req.cache_unit, data: mem[sel][i], due: cyc + lat_of(sel)});
      end
    end
    if (clr) q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(bit v, bit we, int a, logic [63:0] d, logic [7:0] s);
    req_valid      = v;
    req.we         = we;
    req.line_addr  = 8'(a >> 2);
    req.blk_offset = 2'(a);
    req.data       = d;
    req.strb       = s;
    req.way_ind    = 4'($urandom);
    req.cache_unit = cache_unit_e'($urandom_range(0, 3));
    cycle();
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e_rd, e_wr, e_st;
    rst_n = 1'b0; req = '0; req_valid = 1'b0; rdy = 1'b0; clr = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_out_valid", ov_a[s], 1'b0);
      check("rst_cache_unit", out_a[s].cache_unit, EvictUnit);
      check("rst_perf_rd", prd[s], 32'd0);
    end
    sel = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the 16 model-tracked addresses of every instance.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int a = 0; a < 16; a++) drive(1'b1, 1'b1, a, {$urandom, $urandom}, 8'hFF);
    end

    // Latency 1: read address 5, answer one cycle later.
    sel = 0; rdy = 1'b1;
    drive(1'b1, 1'b0, 5, '0, '0);
    idle(3);

    // Latency 3: ten back-to-back reads at full rate.
    sel = 1;
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b0, $urandom_range(0, 15), '0, '0);
    idle(6);

    // Latency 2, output stalled: two reads fit, writes still pass.
    sel = 2; rdy = 1'b0;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, k, '0, '0);
    drive(1'b1, 1'b1, 9, {$urandom, $urandom}, 8'h0F);
    rdy = 1'b1;
    idle(4);

    // Write then read of the same address with random byte strobes.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 6; k++) begin
        int a;
        a = $urandom_range(0, 15);
        drive(1'b1, 1'b1, a, {$urandom, $urandom}, 8'($urandom));
        drive(1'b1, 1'b0, a, '0, '0);
      end
      idle(5);
    end

    // Clear with two reads in flight; a read offered during the clear is refused.
    sel = 1; rdy = 1'b1;
    drive(1'b1, 1'b0, 3, '0, '0);
    drive(1'b1, 1'b0, 4, '0, '0);
    clr = 1'b1;
    drive(1'b1, 1'b0, 6, '0, '0);
    clr = 1'b0;
    idle(5);
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 10 + k, '0, '0);
    rdy = 1'b1;
    idle(6);

    // Reset while reads are in flight and buffered: nothing may come out.
    sel = 2; rdy = 1'b0;
    drive(1'b1, 1'b0, 1, '0, '0);
    drive(1'b1, 1'b0, 2, '0, '0);
    drive(1'b0, 1'b0, 0, '0, '0);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", ov_a[2], 1'b0);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy = 1'b1;
    idle(5);

    // Random traffic on every instance.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int k = 0; k < 250; k++) begin
        rdy = ($urandom_range(0, 9) < 6);
        drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
              $urandom_range(0, 15), {$urandom, $urandom}, 8'($urandom));
      end
      rdy = 1'b1;
      idle(12);
    end

    // Counters: 5 reads, 3 writes, 4 stalled cycles on the 1/1 instance.
    sel = 0; rdy = 1'b1;
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, k, '0, '0);
    rdy = 1'b1;
    idle(1);
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, k + 4, '0, '0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, k, {$urandom, $urandom}, 8'hFF);
    idle(3);
`ifdef AXI_LLC_DATA_WAY_PERF_EN
    e_rd = 32'd5; e_wr = 32'd3; e_st = 32'd4;
`else
    e_rd = 32'd0; e_wr = 32'd0; e_st = 32'd0;
`endif
    check("perf_rd", prd[0], e_rd);
    check("perf_wr", pwr[0], e_wr);
    check("perf_stall", pst[0], e_st);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
